// File: rtl/contador_pkg.sv
// contador_pkg: shared types and elaboration helpers for the up/down counter family
package contador_pkg;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} dir_e;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler: divides enabled clocks by PRESCALE and emits a count tick
//  Clock  in  rising-edge clock
//  Reset  in  asynchronous active-high reset, clears the phase
//  Enable in  advances the phase; phase holds while low
//  Clear  in  synchronous phase clear (driven by the counter's Load)
//  tick   out high on the enabled clock that completes a PRESCALE period
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic tick
);
  localparam int PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] cnt;
  assign tick = Enable & (cnt == LAST);
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) cnt <= '0;
    else if (Clear) cnt <= '0;
    else if (Enable) cnt <= tick ? '0 : cnt + PW'(1);
endmodule

// File: rtl/contador_updown_param.sv
// contador_updown_param: parametrised up/down counter with modulus, wrap/saturate and prescaler
//  Clock         in   rising-edge clock
//  Reset         in   asynchronous active-high reset
//  Enable        in   count enable, also gates the prescaler
//  UpDown        in   1 = up, 0 = down
//  Load          in   synchronous load of min(Entrada, MOD_MAX), beats counting
//  Entrada       in   load value
//  Saida         out  current count, 0..MOD_MAX
//  TerminalCount out  count sits at the limit in the current direction
//  WrapPulse     out  one-cycle pulse on every tick taken at a limit
module contador_updown_param
  import contador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = 2**WIDTH - 1,
  parameter int MODE_SAT = 0,
  parameter int PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             UpDown,
  input  logic             Load,
  input  logic [WIDTH-1:0] Entrada,
  output logic [WIDTH-1:0] Saida,
  output logic             TerminalCount,
  output logic             WrapPulse
);
  if (WIDTH < 1 || PRESCALE < 1 || MOD_MAX < 0 ||
      longint'(MOD_MAX) >= (longint'(1) << WIDTH)) begin : g_bad_param
    $error("contador_updown_param: invalid WIDTH/MOD_MAX/PRESCALE");
  end
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
  localparam bit SAT = MODE_SAT != 0;
  dir_e dir;
  logic tick, at_top, at_bot;
  logic [WIDTH-1:0] step, load_v;
  contador_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Clear  (Load),
    .tick   (tick)
  );
  assign dir           = dir_e'(UpDown);
  assign at_top        = Saida == MAXV;
  assign at_bot        = Saida == '0;
  assign TerminalCount = (dir == CNT_UP) ? at_top : at_bot;
  assign load_v        = (Entrada > MAXV) ? MAXV : Entrada;
  // At a limit the step either wraps to the opposite limit or holds in place.
  always_comb begin
    step = (dir == CNT_UP)
         ? (at_top ? (SAT ? Saida : '0)   : Saida + WIDTH'(1))
         : (at_bot ? (SAT ? Saida : MAXV) : Saida - WIDTH'(1));
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      Saida     <= '0;
      WrapPulse <= 1'b0;
    end else if (Load) begin
      Saida     <= load_v;
      WrapPulse <= 1'b0;
    end else begin
      WrapPulse <= tick & TerminalCount;
      if (tick) Saida <= step;
    end
endmodule

// File: tb/tb_contador_updown_param.sv
// tb_contador_updown_param: five parameter variants driven in lockstep against a behavioural model
module tb_contador_updown_param;
  localparam int N = 5;
  int m_w   [N] = '{4, 4, 4, 4, 6};
  int m_mod [N] = '{15, 9, 15, 15, 40};
  int m_sat [N] = '{0, 1, 0, 0, 1};
  int m_pre [N] = '{1, 1, 3, 4, 2};
  int e_cnt [N];
  int e_ph  [N];
  int e_wp  [N];
  int checks = 0;
  int errors = 0;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ud = 1'b1, ld = 1'b0;
  logic [5:0] ent = '0;
  logic [3:0] q0, q1, q2, q3;
  logic [5:0] q4;
  logic [N-1:0] tc, wp;
  int qa [N];
  assign qa[0] = int'(q0);
  assign qa[1] = int'(q1);
  assign qa[2] = int'(q2);
  assign qa[3] = int'(q3);
  assign qa[4] = int'(q4);
  always #5 clk = ~clk;
  contador_updown_param u0 (.Clock(clk), .Reset(rst), .Enable(en), .UpDown(ud), .Load(ld),
    .Entrada(ent[3:0]), .Saida(q0), .TerminalCount(tc[0]), .WrapPulse(wp[0]));
  contador_updown_param #(.WIDTH(4), .MOD_MAX(9), .MODE_SAT(1)) u1 (.Clock(clk), .Reset(rst),
    .Enable(en), .UpDown(ud), .Load(ld), .Entrada(ent[3:0]), .Saida(q1), .TerminalCount(tc[1]),
    .WrapPulse(wp[1]));
  contador_updown_param #(.PRESCALE(3)) u2 (.Clock(clk), .Reset(rst), .Enable(en), .UpDown(ud),
    .Load(ld), .Entrada(ent[3:0]), .Saida(q2), .TerminalCount(tc[2]), .WrapPulse(wp[2]));
  contador_updown_param #(.PRESCALE(4)) u3 (.Clock(clk), .Reset(rst), .Enable(en), .UpDown(ud),
    .Load(ld), .Entrada(ent[3:0]), .Saida(q3), .TerminalCount(tc[3]), .WrapPulse(wp[3]));
  contador_updown_param #(.WIDTH(6), .MOD_MAX(40), .MODE_SAT(1), .PRESCALE(2)) u4 (.Clock(clk),
    .Reset(rst), .Enable(en), .UpDown(ud), .Load(ld), .Entrada(ent), .Saida(q4),
    .TerminalCount(tc[4]), .WrapPulse(wp[4]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      e_cnt[i] = 0;
      e_ph[i]  = 0;
      e_wp[i]  = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("q%0d", i), qa[i], e_cnt[i]);
      check($sformatf("wp%0d", i), int'(wp[i]), e_wp[i]);
      check($sformatf("tc%0d", i), int'(tc[i]), ud ? int'(e_cnt[i] == m_mod[i]) : int'(e_cnt[i] == 0));
    end
  endtask

  // One clock with the given inputs; the model follows the counting rules directly.
  task automatic step(input bit s_en, input bit s_ud, input bit s_ld, input int s_ent);
    en = s_en; ud = s_ud; ld = s_ld; ent = 6'(s_ent);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      int e;
      bit t;
      e = s_ent % (1 << m_w[i]);
      e_wp[i] = 0;
      if (s_ld) begin
        e_cnt[i] = (e > m_mod[i]) ? m_mod[i] : e;
        e_ph[i] = 0;
      end else if (s_en) begin
        e_ph[i]++;
        t = e_ph[i] == m_pre[i];
        if (t) begin
          e_ph[i] = 0;
          if (s_ud) begin
            if (e_cnt[i] == m_mod[i]) begin
              e_wp[i] = 1;
              if (m_sat[i] == 0) e_cnt[i] = 0;
            end else e_cnt[i]++;
          end else begin
            if (e_cnt[i] == 0) begin
              e_wp[i] = 1;
              if (m_sat[i] == 0) e_cnt[i] = m_mod[i];
            end else e_cnt[i]--;
          end
        end
      end
    end
    #1 check_all();
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("arst_q%0d", i), qa[i], 0);
      check($sformatf("arst_wp%0d", i), int'(wp[i]), 0);
    end
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    for (int i = 0; i < N; i++) check($sformatf("por_q%0d", i), qa[i], 0);
    #1 rst = 1'b0;
    // reset mid-count
    repeat (7) step(1, 1, 0, 0);
    check("t1_q7", int'(q0), 7);
    pulse_reset();
    // wrap up and down
    step(0, 1, 1, 14);
    step(1, 1, 0, 0);
    check("t2_15", int'(q0), 15);
    step(1, 1, 0, 0);
    check("t2_wrap0", int'(q0), 0);
    check("t2_wp_up", int'(wp[0]), 1);
    step(1, 0, 0, 0);
    check("t2_wrap15", int'(q0), 15);
    check("t2_wp_dn", int'(wp[0]), 1);
    step(1, 0, 0, 0);
    check("t2_wp_clr", int'(wp[0]), 0);
    // saturate with modulus 9
    step(0, 1, 1, 7);
    repeat (4) step(1, 1, 0, 0);
    check("t3_hold9", int'(q1), 9);
    check("t3_wp9", int'(wp[1]), 1);
    check("t3_tc9", int'(tc[1]), 1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check("t3_hold0", int'(q1), 0);
    check("t3_wp0", int'(wp[1]), 1);
    // load priority and clamping
    step(1, 1, 1, 5);
    check("t4_load5", int'(q1), 5);
    step(1, 1, 1, 12);
    check("t4_clamp9", int'(q1), 9);
    check("t4_w6_12", int'(q4), 12);
    // prescaler phase
    pulse_reset();
    repeat (2) step(1, 1, 0, 0);
    check("t5_e2", int'(q2), 0);
    step(1, 1, 0, 0);
    check("t5_e3", int'(q2), 1);
    repeat (3) step(1, 1, 0, 0);
    check("t5_e6", int'(q2), 2);
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t5_pre_hold", int'(q2), 2);
    step(1, 1, 0, 0);
    check("t5_resume", int'(q2), 3);
    // direction change mid-prescale
    step(0, 1, 1, 5);
    repeat (2) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    check("t6_nochg", int'(q3), 5);
    step(1, 0, 0, 0);
    check("t6_dec", int'(q3), 4);
    repeat (3) step(1, 0, 0, 0);
    check("t6_gap", int'(q3), 4);
    step(1, 0, 0, 0);
    check("t6_dec2", int'(q3), 3);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 11) == 0), int'($urandom_range(0, 63)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
